iguana_padmux: RTL
==================

// Module: iguana_padmux
// PURPOSE
//  Register-configurable pad multiplexer for Iguana: routes NumFuncs alternate peripheral functions onto
//  NumPads shared pads, converts active-high function OEs to active-low pad OEs, and synchronises
//  and optionally debounces pad inputs. Sits between cheshire_soc peripherals and the pad ring; configured
//  through a reg_ext_slv port of the SoC.
// PARAMETERS
//  NumPads      32         number of muxed pads (1..64)
//  NumFuncs     4          alternate functions per pad; function 0 = GPIO (2..16)
//  CntWidth     8          debounce counter / limit width
//  reg_req_t    logic      register-interface request type (valid, write, addr, wdata[31:0], wstrb[3:0])
//  reg_rsp_t    logic      register-interface response type (ready, rdata[31:0], error)
// PORTS
//  clk_i       in   1                     system clock
//  rst_ni      in   1                     asynchronous active-low reset
//  reg_req_i   in   reg_req_t             config request
//  reg_rsp_o   out  reg_rsp_t             config response
//  func_o_i    in   [NumFuncs][NumPads]   per-function pad output value
//  func_oe_i   in   [NumFuncs][NumPads]   per-function output enable, active-high
//  func_i_o    out  [NumFuncs][NumPads]   per-function input value
//  pad_i       in   [NumPads]             raw pad input (asynchronous)
//  pad_o       out  [NumPads]             pad output value
//  pad_oe_no   out  [NumPads]             pad output enable, active-low
// BEHAVIOUR
//  Single clock clk_i; reset rst_ni asynchronous, active-low; all flops reset to values below.
//  Registers (byte addr, low 12 bits decoded): 0x000+4*p CFG[p]: [3:0] sel, [8] dbnc_en;
//   0x100 DBNC_LIMIT [CntWidth-1:0]; 0x104 LOCK [0]; 0x108 PAD_IN (RO, synced pad_i, bits >=NumPads read 0).
//  Reset: sel=0, dbnc_en=0, DBNC_LIMIT='1, LOCK=0, sync FFs=0, filtered=0, counters=0.
//  Reg port: reg_rsp_o.ready=1 always; rdata/error combinational from request, 0 when !valid.
//   Writes take effect at the clock edge of the accepted cycle; wstrb honoured per byte.
//   error=1 on: unmapped addr, write to PAD_IN, CFG/DBNC_LIMIT write while LOCK=1 (write dropped).
//   sel write value >=NumFuncs is stored as written (illegal select).
//  Output path (combinational): sel<NumFuncs: pad_o=func_o_i[sel][p], pad_oe_no=~func_oe_i[sel][p];
//   illegal sel: pad_o=0, pad_oe_no=1 (pad tristated). During reset sel=0 -> pads follow GPIO.
//  Input path: 2-FF synchroniser sync[p]; filtered[p]=sync[p] when dbnc_en=0 (latency pad_i->func_i_o 2 cycles).
//   dbnc_en=1, per-pad counter cnt: sync==filt -> cnt<=0; sync!=filt & cnt>=DBNC_LIMIT -> filt<=sync,
//   cnt<=0; else cnt<=cnt+1. Stable change latency = 2+DBNC_LIMIT+1 cycles; glitch shorter resets cnt.
//   Lowering DBNC_LIMIT below a running cnt flips filt on next cycle (>= compare). Clearing dbnc_en:
//   cnt<=0, filt<=sync same edge. Counter never wraps (max DBNC_LIMIT).
//  func_i_o[f][p]=filtered[p] if sel[p]==f, else 0; illegal sel -> all functions see 0.
//  Changing sel re-routes combinationally; filter state unaffected.
//  Reset mid-operation: all state returns to reset values immediately; no partial register write.
// CONFIGURATION
//  IGUANA_PADMUX_LOCK_EN defined: LOCK is write-1-sticky until reset (writing 0 ignored, no error);
//   while set, CFG/DBNC_LIMIT writes are dropped with error=1; reads unaffected.
//  Not defined: no LOCK flop; 0x104 reads 0, writes accepted with error=0 and no effect; config always writable.
// TESTING
//  Reset, no writes: func_o_i[0][5]=1, func_oe_i[0][5]=1 -> pad_o[5]=1, pad_oe_no[5]=0; func_i_o=0.
//  Write CFG[3]=0x2; pad_i[3] 0->1 -> func_i_o[2][3]=1 exactly 2 cycles later, func_i_o[0][3]=0.
//  CFG[7]=0x100, DBNC_LIMIT=4; 3-cycle pulse on pad_i[7] -> no change; stable 1 -> func_i_o[0][7]=1 after 7 cycles.
//  CFG[1]=0xF (NumFuncs=4) -> pad_oe_no[1]=1, pad_o[1]=0, all func_i_o[*][1]=0; readback 0xF.
//  LOCK_EN: write LOCK=1, then CFG[0]=1 -> error=1, CFG[0] reads 0; write LOCK=0 -> LOCK still 1.
//  Read 0x200 -> error=1, rdata=0; assert rst_ni mid-debounce -> cnt, filt, sel return to 0 same cycle.

Source files
------------

// File: rtl/iguana_padmux.sv
// iguana_padmux: register-configurable pad multiplexer.
// Routes NumFuncs peripheral functions onto NumPads shared pads.
// Converts active-high function output enables into active-low pad output enables.
// Synchronises each pad input and can optionally debounce it.
//
// Ports
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   reg_req_i/reg_rsp_o  config register port (always ready, combinational response)
//   func_o_i, func_oe_i  per-function pad output value / active-high output enable
//   func_i_o             per-function input value (0 unless the pad selects that function)
//   pad_i                raw asynchronous pad input
//   pad_o, pad_oe_no     pad output value / active-low pad output enable
//
// Configuration macro: IGUANA_PADMUX_LOCK_EN
//   Defined: LOCK (0x104) is write-1-sticky and blocks CFG/DBNC_LIMIT writes.
//   Undefined: 0x104 reads 0 and ignores writes.

package iguana_padmux_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;
endpackage

module iguana_padmux #(
    parameter int unsigned NumPads  = 32,
    parameter int unsigned NumFuncs = 4,
    parameter int unsigned CntWidth = 8,
    parameter type reg_req_t = iguana_padmux_pkg::reg_req_t,
    parameter type reg_rsp_t = iguana_padmux_pkg::reg_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  reg_req_t                           reg_req_i,
    output reg_rsp_t                           reg_rsp_o,
    input  logic [NumFuncs-1:0][NumPads-1:0]   func_o_i,
    input  logic [NumFuncs-1:0][NumPads-1:0]   func_oe_i,
    output logic [NumFuncs-1:0][NumPads-1:0]   func_i_o,
    input  logic [NumPads-1:0]                 pad_i,
    output logic [NumPads-1:0]                 pad_o,
    output logic [NumPads-1:0]                 pad_oe_no
);

    localparam logic [4:0] NumFuncsW = 5'(NumFuncs);

    logic [CntWidth-1:0] limit_q;
    logic                lock;
    logic                cfg_wr, limit_wr, lock_wr;
    logic [5:0]          cfg_idx;
    logic [31:0]         wmask;
    logic [31:0]         pad_in_word;
    logic [NumPads-1:0]  sync_q;
    // Padded to 64 entries so the 6-bit address field indexes it exactly.
    logic [63:0][8:0]    cfg_word;

    assign cfg_idx = reg_req_i.addr[7:2];
    assign wmask   = {{8{reg_req_i.wstrb[3]}}, {8{reg_req_i.wstrb[2]}},
                      {8{reg_req_i.wstrb[1]}}, {8{reg_req_i.wstrb[0]}}};

    // Register decode. Low two address bits are ignored.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        cfg_wr          = 1'b0;
        limit_wr        = 1'b0;
        lock_wr         = 1'b0;
        if (reg_req_i.valid) begin
            if (reg_req_i.addr[11:8] == 4'h0) begin
                if (32'(cfg_idx) < NumPads) begin
                    if (reg_req_i.write) begin
                        if (lock) reg_rsp_o.error = 1'b1;
                        else      cfg_wr          = 1'b1;
                    end else begin
                        reg_rsp_o.rdata = {23'b0, cfg_word[cfg_idx]};
                    end
                end else begin
                    reg_rsp_o.error = 1'b1;
                end
            end else begin
                case (reg_req_i.addr[11:2])
                    10'h040: begin
                        if (reg_req_i.write) begin
                            if (lock) reg_rsp_o.error = 1'b1;
                            else      limit_wr        = 1'b1;
                        end else begin
                            reg_rsp_o.rdata = 32'(limit_q);
                        end
                    end
                    10'h041: begin
                        if (reg_req_i.write) lock_wr         = 1'b1;
                        else                 reg_rsp_o.rdata = {31'b0, lock};
                    end
                    10'h042: begin
                        if (reg_req_i.write) reg_rsp_o.error = 1'b1;
                        else                 reg_rsp_o.rdata = pad_in_word;
                    end
                    default: reg_rsp_o.error = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            limit_q <= '1;
        end else if (limit_wr) begin
            limit_q <= (limit_q & ~wmask[CntWidth-1:0]) |
                       (reg_req_i.wdata[CntWidth-1:0] & wmask[CntWidth-1:0]);
        end
    end

`ifdef IGUANA_PADMUX_LOCK_EN
    logic lock_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (lock_wr && reg_req_i.wstrb[0] && reg_req_i.wdata[0]) begin
            lock_q <= 1'b1;
        end
    end
    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    for (genvar i = 0; i < 32; i++) begin : g_pad_in
        if (i < NumPads) begin : g_real
            assign pad_in_word[i] = sync_q[i];
        end else begin : g_zero
            assign pad_in_word[i] = 1'b0;
        end
    end

    for (genvar p = 0; p < 64; p++) begin : g_cfg_word
        if (p >= NumPads) begin : g_zero
            assign cfg_word[p] = '0;
        end
    end

    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        logic [3:0]          sel_r;
        logic                dbnc_en_r, sync1_r, sync2_r, filt_r, filtered, legal;
        logic [CntWidth-1:0] cnt_r;
        logic [15:0]         col_o, col_oe;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sel_r     <= '0;
                dbnc_en_r <= 1'b0;
            end else if (cfg_wr && cfg_idx == 6'(p)) begin
                if (reg_req_i.wstrb[0]) sel_r     <= reg_req_i.wdata[3:0];
                if (reg_req_i.wstrb[1]) dbnc_en_r <= reg_req_i.wdata[8];
            end
        end

        // The >= compare means a lowered limit releases a running count at once.
        // The counter therefore never exceeds the limit.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
                filt_r  <= 1'b0;
                cnt_r   <= '0;
            end else begin
                sync1_r <= pad_i[p];
                sync2_r <= sync1_r;
                if (!dbnc_en_r) begin
                    cnt_r  <= '0;
                    filt_r <= sync2_r;
                end else if (sync2_r == filt_r) begin
                    cnt_r  <= '0;
                end else if (cnt_r >= limit_q) begin
                    filt_r <= sync2_r;
                    cnt_r  <= '0;
                end else begin
                    cnt_r  <= cnt_r + CntWidth'(1);
                end
            end
        end

        assign filtered    = dbnc_en_r ? filt_r : sync2_r;
        assign legal       = {1'b0, sel_r} < NumFuncsW;
        assign sync_q[p]   = sync2_r;
        assign cfg_word[p] = {dbnc_en_r, 4'b0, sel_r};

        for (genvar f = 0; f < 16; f++) begin : g_col
            if (f < NumFuncs) begin : g_real
                assign col_o[f]  = func_o_i[f][p];
                assign col_oe[f] = func_oe_i[f][p];
            end else begin : g_zero
                assign col_o[f]  = 1'b0;
                assign col_oe[f] = 1'b0;
            end
        end

        // Illegal select tristates the pad.
        assign pad_o[p]     = legal & col_o[sel_r];
        assign pad_oe_no[p] = ~(legal & col_oe[sel_r]);

        for (genvar f = 0; f < NumFuncs; f++) begin : g_fin
            assign func_i_o[f][p] = (sel_r == 4'(f)) & filtered;
        end
    end

    // Address/data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{reg_req_i, wmask, lock_wr};

endmodule
